cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
//  MIPS32 CP0 register file; the consumer end of the exception detector's except_type/badvaddr interface.
//  - Holds Status/Cause/EPC/BadVAddr/Count/Compare.
//  - Commits exceptions and ERET in the M stage.
//  - Runs the Count/Compare timer.
//  - Feeds cp0_status/cp0_cause/cp0_epc back to the detector. Serves MFC0 reads and MTC0 writes.
// PARAMETERS
//  COUNT_DIV  2             Count increments once every COUNT_DIV clocks (1 or 2 only)
//  PRID_VAL   32'h0000_4220 read-only PRId value
// PORTS
//  clk            in   1   clock; all state updates on posedge clk
//  rst            in   1   reset, synchronous, active-high
//  we_i           in   1   MTC0 write enable (M stage)
//  waddr_i        in   5   MTC0 register number
//  wdata_i        in   32  MTC0 data
//  raddr_i        in   5   MFC0 register number
//  rdata_o        out  32  MFC0 data, combinational from current register state (no write bypass)
//  except_type_i  in   32  exception code from the detector; 0 = none
//  pc_i           in   32  PC of the M-stage instruction
//  in_delayslot_i in   1   M-stage instruction is in a branch delay slot
//  badvaddr_i     in   32  faulting address from the detector
//  ext_int_i      in   6   hardware interrupt lines, level-sensitive
//  status_o       out  32  Status register
//  cause_o        out  32  Cause register
//  epc_o          out  32  EPC register
//  count_o        out  32  Count register
//  compare_o      out  32  Compare register
//  badvaddr_o     out  32  BadVAddr register
//  timer_int_o    out  1   timer interrupt pending (= Cause[30])
// BEHAVIOUR
//  Reset values (on rst at posedge):
//  - Status = 32'h0040_0000 (BEV=1).
//  - Cause, EPC, BadVAddr, Count, Compare = 0.
//  - timer_int_o = 0.
//  - A mid-operation rst discards a same-cycle exception and any write.
//  Register numbers: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15.
//  - Unmapped reads return 0. Unmapped writes are ignored.
//  Timer:
//  - Count += 1 every COUNT_DIV clocks via the divider tick; wraps 32'hFFFF_FFFF -> 0.
//  - When Compare != 0 and Count == Compare, Cause[30] is set on the next edge and held.
//  - An MTC0 write to Compare clears Cause[30]; the clear wins over a same-cycle match.
//  - An MTC0 write to Count loads wdata_i and overrides that cycle's increment.
//  Cause IP bits:
//  - Cause[15:10] <= ext_int_i every cycle, sampled.
//  - Cause[9:8] are written only by MTC0.
//  Writable masks:
//  - Status: bits 15:8 (IM), 1 (EXL), 0 (IE).
//  - Cause: bits 9:8 only.
//  - EPC, Compare, Count: full 32 bits. BadVAddr is read-only to MTC0.
//  Exception commit (except_type_i in {01,04,05,08,09,0a,0c,0d}), at one edge:
//  - If Status.EXL == 0:
//    - EPC <= in_delayslot_i ? pc_i-4 : pc_i.
//    - Cause[31] (BD) <= in_delayslot_i.
//  - If Status.EXL == 1: EPC and BD are unchanged.
//  - Status.EXL <= 1.
//  - Cause[6:2] (ExcCode) <= code: 01->0, 04->4, 05->5, 08->8, 09->9, 0a->10, 0c->12, 0d->13.
//  - For codes 04/05: BadVAddr <= badvaddr_i.
//  ERET (except_type_i == 32'h0e): Status.EXL <= 0; nothing else changes.
//  Other except_type_i values: treated as none.
//  Simultaneous events:
//  - An exception or ERET suppresses a same-cycle MTC0 write to any register.
//  - Timer and IP sampling still update.
//  Arithmetic: pc_i-4 is modulo 2^32.
// STRUCTURE
//  Package cp0_pkg:
//  - CP0 register-number localparams.
//  - except_type encodings (EXC_INT..EXC_ERET).
//  - ExcCode values.
//  - Status/Cause bit-position constants.
//  Sub-module cp0_timer:
//  - Owns the divider, Count and Compare, plus match/clear.
//  - Outputs count, compare and timer_set.
//  - Top keeps Status/Cause/EPC/BadVAddr, the commit logic and the read mux.
// TESTING
//  1. Reset: after rst, status_o=32'h0040_0000; cause_o/epc_o/count_o=0; rdata_o(15)=PRID_VAL.
//  2. Timer (COUNT_DIV=2):
//     - Write Compare=5 -> Cause[30]=1 when count_o reaches 5; count_o=5 after 10 clocks.
//     - Then write Compare=9 -> timer_int_o=0 the next cycle.
//  3. Syscall:
//     - Syscall (08) at pc_i=32'hBFC0_0100, not in delay slot -> epc_o=32'hBFC0_0100, ExcCode=8, EXL=1.
//     - Then ERET -> EXL=0, EPC unchanged.
//  4. Delay-slot AdEL (04) at pc_i=32'h8000_0010, badvaddr_i=32'h8000_0003:
//     - epc_o=32'h8000_000C, cause_o[31]=1, badvaddr_o=32'h8000_0003.
//  5. Nested exception:
//     - With EXL=1, issue RI (0a) at a new pc -> EPC unchanged, ExcCode=10.
//     - The same-cycle MTC0 to Status is ignored.
//  6. Interrupt lines: drive ext_int_i=6'b000001 -> cause_o[10]=1 one edge later; clear -> 0 one edge later.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 register numbers, exception encodings and register bit positions
// shared by the CP0 register file and its timer.
package cp0_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  localparam logic [31:0] EXC_INT  = 32'h01;
  localparam logic [31:0] EXC_ADEL = 32'h04;
  localparam logic [31:0] EXC_ADES = 32'h05;
  localparam logic [31:0] EXC_SYS  = 32'h08;
  localparam logic [31:0] EXC_BP   = 32'h09;
  localparam logic [31:0] EXC_RI   = 32'h0a;
  localparam logic [31:0] EXC_OV   = 32'h0c;
  localparam logic [31:0] EXC_TR   = 32'h0d;
  localparam logic [31:0] EXC_ERET = 32'h0e;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;
  localparam logic [4:0] EXCCODE_TR   = 5'd13;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int CA_EXC_LO  = 2;
  localparam int CA_EXC_HI  = 6;
  localparam int CA_IPSW_LO = 8;
  localparam int CA_IPSW_HI = 9;
  localparam int CA_IPHW_LO = 10;
  localparam int CA_IPHW_HI = 15;
  localparam int CA_TI      = 30;
  localparam int CA_BD      = 31;

  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  typedef struct packed {
    logic       valid;
    logic       bad;
    logic [4:0] code;
  } exc_info_t;

  function automatic exc_info_t exc_decode(input logic [31:0] t);
    exc_info_t r;
    r = '{valid: 1'b1, bad: 1'b0, code: EXCCODE_INT};
    case (t)
      EXC_INT:  r.code = EXCCODE_INT;
      EXC_ADEL: begin r.code = EXCCODE_ADEL; r.bad = 1'b1; end
      EXC_ADES: begin r.code = EXCCODE_ADES; r.bad = 1'b1; end
      EXC_SYS:  r.code = EXCCODE_SYS;
      EXC_BP:   r.code = EXCCODE_BP;
      EXC_RI:   r.code = EXCCODE_RI;
      EXC_OV:   r.code = EXCCODE_OV;
      EXC_TR:   r.code = EXCCODE_TR;
      default:  r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: clock divider, Count, Compare and the
// match detect that raises the timer interrupt in Cause.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cnt_we_i,
  input  logic        cmp_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_set_o
);

  logic        div_q;
  logic        tick;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;

  assign tick = (COUNT_DIV == 1) ? 1'b1 : div_q;

  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    if (cnt_we_i)
      count_d = wdata_i;
    else if (tick)
      count_d = count_q + 32'd1;
    if (cmp_we_i)
      compare_d = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      div_q     <= ~div_q;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_set_o = (compare_q != '0) && (count_q == compare_q);

endmodule

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file: exception/ERET commit, MTC0/MFC0 access
// and interrupt sampling around the Count/Compare timer.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int          COUNT_DIV = 2,
  parameter logic [31:0] PRID_VAL  = 32'h0000_4220
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  input  logic [31:0] except_type_i,
  input  logic [31:0] pc_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] badvaddr_i,
  input  logic [5:0]  ext_int_i,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] bva_q, bva_d;

  exc_info_t exc;
  logic      eret;
  logic      mtc0;
  logic      cnt_we;
  logic      cmp_we;
  logic      timer_set;

  assign exc    = exc_decode(except_type_i);
  assign eret   = (except_type_i == EXC_ERET);
  assign mtc0   = we_i & ~exc.valid & ~eret;
  assign cnt_we = mtc0 & (waddr_i == CP0_COUNT);
  assign cmp_we = mtc0 & (waddr_i == CP0_COMPARE);

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .cnt_we_i    (cnt_we),
    .cmp_we_i    (cmp_we),
    .wdata_i     (wdata_i),
    .count_o     (count_o),
    .compare_o   (compare_o),
    .timer_set_o (timer_set)
  );

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    bva_d    = bva_q;
    cause_d[CA_IPHW_HI:CA_IPHW_LO] = ext_int_i;
    // A Compare write acknowledges the timer even on a live match
    if (cmp_we)
      cause_d[CA_TI] = 1'b0;
    else if (timer_set)
      cause_d[CA_TI] = 1'b1;
    if (mtc0) begin
      case (waddr_i)
        CP0_STATUS:
          status_d = (status_q & ~STATUS_WMASK)
                   | (wdata_i & STATUS_WMASK);
        CP0_CAUSE:
          cause_d[CA_IPSW_HI:CA_IPSW_LO] =
            wdata_i[CA_IPSW_HI:CA_IPSW_LO];
        CP0_EPC:
          epc_d = wdata_i;
        default: ;
      endcase
    end
    if (exc.valid) begin
      if (!status_q[ST_EXL]) begin
        epc_d = in_delayslot_i ? pc_i - 32'd4 : pc_i;
        cause_d[CA_BD] = in_delayslot_i;
      end
      status_d[ST_EXL] = 1'b1;
      cause_d[CA_EXC_HI:CA_EXC_LO] = exc.code;
      if (exc.bad)
        bva_d = badvaddr_i;
    end else if (eret) begin
      status_d[ST_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
      cause_q  <= '0;
      epc_q    <= '0;
      bva_q    <= '0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      bva_q    <= bva_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      CP0_BADVADDR: rdata_o = bva_q;
      CP0_COUNT:    rdata_o = count_o;
      CP0_COMPARE:  rdata_o = compare_o;
      CP0_STATUS:   rdata_o = status_q;
      CP0_CAUSE:    rdata_o = cause_q;
      CP0_EPC:      rdata_o = epc_q;
      CP0_PRID:     rdata_o = PRID_VAL;
      default:      rdata_o = '0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = bva_q;
  assign timer_int_o = cause_q[CA_TI];

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed scenarios plus random traffic
// checked against a field-level model of the CP0 registers.
module tb_cp0_regfile;

  localparam logic [31:0] PRID = 32'h0000_4220;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_i;
  logic [31:0] rdata_o;
  logic [31:0] except_type_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] badvaddr_i;
  logic [5:0]  ext_int_i;
  logic [31:0] status_o, cause_o, epc_o;
  logic [31:0] count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_regfile #(.COUNT_DIV(2), .PRID_VAL(PRID)) dut (
    .clk            (clk),
    .rst            (rst),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .wdata_i        (wdata_i),
    .raddr_i        (raddr_i),
    .rdata_o        (rdata_o),
    .except_type_i  (except_type_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .badvaddr_i     (badvaddr_i),
    .ext_int_i      (ext_int_i),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .count_o        (count_o),
    .compare_o      (compare_o),
    .badvaddr_o     (badvaddr_o),
    .timer_int_o    (timer_int_o)
  );

  // Model state, kept as architectural fields
  int          m_edges;
  logic [31:0] m_cnt, m_cmp, m_epc, m_bva;
  logic        m_bd, m_ti, m_exl, m_ie;
  logic [4:0]  m_exc;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [7:0]  m_im;

  function automatic logic [31:0] m_status();
    return {9'b0, 1'b1, 6'b0, m_im, 6'b0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'b0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bva;
      5'd9:    return m_cnt;
      5'd11:   return m_cmp;
      5'd12:   return m_status();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic is_exc, is_eret, wr;
    logic [31:0] n_cnt;
    logic match;
    if (rst) begin
      m_edges = 0; m_cnt = 0; m_cmp = 0; m_epc = 0; m_bva = 0;
      m_bd = 0; m_ti = 0; m_exl = 0; m_ie = 0; m_exc = 0;
      m_iphw = 0; m_ipsw = 0; m_im = 0;
      return;
    end
    is_exc = except_type_i inside {32'h01, 32'h04, 32'h05, 32'h08,
                                   32'h09, 32'h0a, 32'h0c, 32'h0d};
    is_eret = (except_type_i == 32'h0e);
    wr = we_i && !is_exc && !is_eret;
    m_edges++;
    match = (m_cmp != 0) && (m_cnt == m_cmp);
    n_cnt = (m_edges % 2 == 0) ? m_cnt + 1 : m_cnt;
    if (wr && waddr_i == 5'd9) n_cnt = wdata_i;
    if (wr && waddr_i == 5'd11) begin
      m_cmp = wdata_i;
      m_ti = 0;
    end else if (match) begin
      m_ti = 1;
    end
    m_cnt = n_cnt;
    m_iphw = ext_int_i;
    if (wr && waddr_i == 5'd12) begin
      m_im = wdata_i[15:8];
      m_exl = wdata_i[1];
      m_ie = wdata_i[0];
    end
    if (wr && waddr_i == 5'd13) m_ipsw = wdata_i[9:8];
    if (wr && waddr_i == 5'd14) m_epc = wdata_i;
    if (is_exc) begin
      if (!m_exl) begin
        m_epc = in_delayslot_i ? pc_i - 4 : pc_i;
        m_bd = in_delayslot_i;
      end
      m_exl = 1;
      m_exc = (except_type_i == 32'h01) ? 5'd0 : except_type_i[4:0];
      if (except_type_i == 32'h04 || except_type_i == 32'h05)
        m_bva = badvaddr_i;
    end else if (is_eret) begin
      m_exl = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("status", status_o, m_status());
    chk("cause", cause_o, m_cause());
    chk("epc", epc_o, m_epc);
    chk("count", count_o, m_cnt);
    chk("compare", compare_o, m_cmp);
    chk("badvaddr", badvaddr_o, m_bva);
    chk("timer_int", {31'b0, timer_int_o}, {31'b0, m_ti});
    chk("rdata", rdata_o, m_read(raddr_i));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    rst = 0; we_i = 0; waddr_i = 0; wdata_i = 0;
    except_type_i = 0; pc_i = 0; in_delayslot_i = 0; badvaddr_i = 0;
  endtask

  initial begin
    idle();
    raddr_i = 5'd15;
    ext_int_i = 0;
    rst = 1;
    step();
    chk("rst_status", status_o, 32'h0040_0000);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_count", count_o, 32'h0);
    chk("rst_prid", rdata_o, PRID);
    rst = 0;

    // Timer: Compare=5 then re-arm with 9
    we_i = 1; waddr_i = 5'd11; wdata_i = 32'd5;
    step();
    idle();
    raddr_i = 5'd9;
    repeat (9) step();
    chk("cnt_after_10", count_o, 32'd5);
    step();
    chk("ti_set", {31'b0, timer_int_o}, 32'd1);
    chk("cause30", {31'b0, cause_o[30]}, 32'd1);
    we_i = 1; waddr_i = 5'd11; wdata_i = 32'd9;
    step();
    idle();
    chk("ti_clear", {31'b0, timer_int_o}, 32'd0);

    // Syscall then ERET
    except_type_i = 32'h08; pc_i = 32'hBFC0_0100;
    raddr_i = 5'd13;
    step();
    idle();
    chk("sys_epc", epc_o, 32'hBFC0_0100);
    chk("sys_code", {27'b0, cause_o[6:2]}, 32'd8);
    chk("sys_exl", {31'b0, status_o[1]}, 32'd1);
    except_type_i = 32'h0e;
    step();
    idle();
    chk("eret_exl", {31'b0, status_o[1]}, 32'd0);
    chk("eret_epc", epc_o, 32'hBFC0_0100);

    // Delay-slot AdEL
    except_type_i = 32'h04; pc_i = 32'h8000_0010;
    in_delayslot_i = 1; badvaddr_i = 32'h8000_0003;
    raddr_i = 5'd8;
    step();
    idle();
    chk("adel_epc", epc_o, 32'h8000_000C);
    chk("adel_bd", {31'b0, cause_o[31]}, 32'd1);
    chk("adel_bva", badvaddr_o, 32'h8000_0003);

    // Nested RI with a same-cycle Status write
    except_type_i = 32'h0a; pc_i = 32'h8000_0200;
    we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_FF00;
    raddr_i = 5'd12;
    step();
    idle();
    chk("nest_epc", epc_o, 32'h8000_000C);
    chk("nest_code", {27'b0, cause_o[6:2]}, 32'd10);
    chk("nest_status", status_o, 32'h0040_0002);
    except_type_i = 32'h0e;
    step();
    idle();

    // Interrupt line sampling
    ext_int_i = 6'b000001;
    step();
    chk("ip2_set", {31'b0, cause_o[10]}, 32'd1);
    ext_int_i = 6'b000000;
    step();
    chk("ip2_clr", {31'b0, cause_o[10]}, 32'd0);

    // Reset mid-operation discards exception and write
    rst = 1; except_type_i = 32'h08; pc_i = 32'h1234_5678;
    we_i = 1; waddr_i = 5'd14; wdata_i = 32'hDEAD_BEEF;
    step();
    idle();
    chk("mid_rst_status", status_o, 32'h0040_0000);
    chk("mid_rst_epc", epc_o, 32'h0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] et [12];
      logic [4:0]  wa [9];
      et = '{32'h0, 32'h0, 32'h0, 32'h01, 32'h04, 32'h05, 32'h08,
             32'h09, 32'h0a, 32'h0c, 32'h0d, 32'h0e};
      wa = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
             5'd0, 5'd20};
      rst = ($urandom_range(0, 99) < 2);
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = wa[$urandom_range(0, 8)];
      wdata_i = $urandom;
      if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
        wdata_i = m_cnt + $urandom_range(0, 6);
      if (waddr_i == 5'd9 && $urandom_range(0, 1) == 1)
        wdata_i = (m_cmp != 0) ? m_cmp - $urandom_range(0, 4)
                               : 32'hFFFF_FFFE;
      except_type_i = ($urandom_range(0, 3) == 0)
                      ? et[$urandom_range(0, 11)] : 32'h0;
      if ($urandom_range(0, 49) == 0) except_type_i = 32'h03;
      pc_i = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 19) == 0) pc_i = 32'h0;
      in_delayslot_i = $urandom_range(0, 1);
      badvaddr_i = $urandom;
      ext_int_i = 6'($urandom);
      raddr_i = 5'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
